match_scheduler: RTL and testbench
==================================

Name: match_scheduler

Overview:
Sequencer for the brute-force pattern-search datapath. It drives the pattern ROM and text ROM addresses, compares the returned bytes and walks every candidate alignment in a programmable text window. It counts and reports matches, and exposes a start/busy/done handshake to the top-level search block. It replaces the hard-wired end-of-text and end-of-pattern comparators with run-time bounds, and it handles the 1-cycle latency of the synchronous ROMs explicitly.

Parameters:
TEXT_AW, 14, text ROM address width
PAT_AW, 3, pattern ROM address width (max pattern length 2**PAT_AW = 8)
DW, 8, character width
CNT_W, 8, match counter width (saturating)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle request, sampled only in IDLE or DONE
abort  in  1  cancel the current scan
start_addr  in  TEXT_AW  first text address of the window
text_end  in  TEXT_AW  exclusive end address of the window (system default 11064)
pat_len  in  PAT_AW+1  pattern length, 1..8
text_addr  out  TEXT_AW  text ROM address
pat_addr  out  PAT_AW  pattern ROM address
text_data  in  DW  text ROM data, valid 1 cycle after text_addr
pat_data  in  DW  pattern ROM data, valid 1 cycle after pat_addr
busy  out  1  scan in progress
done  out  1  level; scan finished normally, held until next start
match_valid  out  1  one-cycle pulse per match found
match_addr  out  TEXT_AW  alignment base of the latest match
match_count  out  CNT_W  matches found in the current scan

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; internal base, offset and latched configuration registers are 0.
- start_addr, text_end and pat_len are latched on an accepted start. Input changes during a scan have no effect.
- States: IDLE, FETCH, COMPARE, DONE.
- IDLE or DONE with start=1:
  - Clear match_count and done.
  - Set base=start_addr, off=0.
  - If pat_len==0, pat_len>8, or start_addr+pat_len>text_end (compute in TEXT_AW+1 bits): go to DONE next cycle with count 0.
  - Otherwise go to FETCH.
- FETCH: drive text_addr=base+off and pat_addr=off; busy=1. Next state is COMPARE.
- COMPARE: ROM data is valid this cycle.
  - Equal and off==pat_len-1: a match. Pulse match_valid, set match_addr=base, increment match_count (saturate at 2**CNT_W-1). Then base+=1, off=0.
  - Equal and off<pat_len-1: off+=1, go to FETCH.
  - Not equal: base+=1, off=0.
  - Whenever base advances: if new base+pat_len>text_end, go to DONE; otherwise go to FETCH.
- Overlapping matches are counted, because base always advances by exactly 1.
- Throughput is 2 cycles per byte compared. No pipelining of ROM reads is required.
- DONE: busy=0, done=1; match_count and match_addr hold. start restarts the scan; otherwise stay in DONE.
- abort=1 in FETCH or COMPARE:
  - Go to IDLE next cycle. busy=0, done stays 0.
  - match_count holds its partial value.
  - A match in the same COMPARE cycle is discarded: no pulse, no increment.
  - abort in IDLE or DONE is ignored.
- start while busy is ignored. If start and abort are both high while busy, abort wins.
- text_addr and pat_addr hold their last value outside FETCH.
- All arithmetic is unsigned. The end-bound check uses TEXT_AW+1 bits so that text_end=2**TEXT_AW-1 does not wrap.

Decomposition:
- Package search_pkg holds:
  - the state enum (IDLE, FETCH, COMPARE, DONE);
  - constants TEXT_END_DEFAULT=14'd11064 and PAT_LEN_DEFAULT=4;
  - the width localparams.
- One sub-module, sat_counter: parameterised width, synchronous clear, enable, saturates at all-ones. It is used for match_count.
- The FSM and address registers stay in match_scheduler.

Test Plan:
- Text "abcabcab" at 0..7, pattern "abc", pat_len=3, start_addr=0, text_end=8 -> match_valid with match_addr 0 then 3. done=1 with match_count=2. busy deasserts the cycle done rises.
- Text "aaaa", pattern "aa", pat_len=2, window 0..4 -> 3 matches at 0, 1, 2 (overlap counted); match_count=3.
- 300 bytes of 'a', pattern "a", pat_len=1 -> match_count saturates at 255. done=1 after all 300 alignments; 300 match_valid pulses.
- start_addr=6, text_end=8, pat_len=3 -> DONE one cycle after start. match_count=0, no text_addr activity. pat_len=0 behaves the same.
- Abort on the COMPARE cycle of the second match in the first scenario -> no second pulse, match_count=1, IDLE next cycle, done=0. A new start clears the count to 0.
- Assert rst low mid-scan (asynchronously, between edges) -> all outputs 0 immediately. After release, state is IDLE and start runs a clean scan with the correct count.

Source files
------------

// File: rtl/search_pkg.sv
// Shared types and constants for the brute-force pattern-search datapath.
// Width defaults here feed the match_scheduler parameter defaults.
package search_pkg;

    localparam int DEF_TEXT_AW = 14;
    localparam int DEF_PAT_AW  = 3;
    localparam int DEF_DW      = 8;
    localparam int DEF_CNT_W   = 8;

    localparam logic [DEF_TEXT_AW-1:0] TEXT_END_DEFAULT = 14'd11064;
    localparam int                     PAT_LEN_DEFAULT  = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/match_scheduler_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/match_scheduler.sv
// Walks every alignment of the pattern over a text window, two cycles per byte
// compared (address out, then compare the synchronous ROM data).
//
// state   | meaning
// IDLE    | waiting for start; also where an abort lands
// FETCH   | text_addr/pat_addr presented to the ROMs
// COMPARE | ROM bytes valid; advance offset or base
// DONE    | window exhausted, results held until next start
module match_scheduler
    import search_pkg::*;
#(
    parameter int TEXT_AW = DEF_TEXT_AW,
    parameter int PAT_AW  = DEF_PAT_AW,
    parameter int DW      = DEF_DW,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [TEXT_AW-1:0] start_addr,
    input  logic [TEXT_AW-1:0] text_end,
    input  logic [PAT_AW:0]    pat_len,
    output logic [TEXT_AW-1:0] text_addr,
    output logic [PAT_AW-1:0]  pat_addr,
    input  logic [DW-1:0]      text_data,
    input  logic [DW-1:0]      pat_data,
    output logic               busy,
    output logic               done,
    output logic               match_valid,
    output logic [TEXT_AW-1:0] match_addr,
    output logic [CNT_W-1:0]   match_count
);

    localparam int EXT_W = TEXT_AW + 1;
    localparam logic [PAT_AW:0] PAT_MAX = (PAT_AW+1)'(1) << PAT_AW;

    state_t               state_q, state_d;
    logic [TEXT_AW-1:0]   base_q, base_d;
    logic [PAT_AW-1:0]    off_q, off_d;
    logic [TEXT_AW-1:0]   text_end_q, text_end_d;
    logic [PAT_AW:0]      pat_len_q, pat_len_d;
    logic [TEXT_AW-1:0]   text_addr_q, text_addr_d;
    logic [PAT_AW-1:0]    pat_addr_q, pat_addr_d;
    logic                 match_valid_q, match_valid_d;
    logic [TEXT_AW-1:0]   match_addr_q, match_addr_d;

    logic                 cnt_clr;
    logic                 cnt_en;
    logic                 cfg_bad;
    logic                 end_hit;
    logic                 last_off;
    logic                 bytes_eq;
    logic [PAT_AW-1:0]    off_inc;
    logic [EXT_W-1:0]     start_span;
    logic [EXT_W-1:0]     next_span;

    // Bounds are checked one bit wider so text_end near the top of the ROM cannot wrap.
    always_comb begin
        start_span = {1'b0, start_addr} + {{(TEXT_AW-PAT_AW){1'b0}}, pat_len};
        next_span  = {1'b0, base_q} + EXT_W'(1) + {{(TEXT_AW-PAT_AW){1'b0}}, pat_len_q};
        cfg_bad    = (pat_len == '0) || (pat_len > PAT_MAX) || (start_span > {1'b0, text_end});
        end_hit    = next_span > {1'b0, text_end_q};
        last_off   = {1'b0, off_q} == (pat_len_q - (PAT_AW+1)'(1));
        bytes_eq   = text_data == pat_data;
        off_inc    = off_q + PAT_AW'(1);
    end

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        off_d         = off_q;
        text_end_d    = text_end_q;
        pat_len_d     = pat_len_q;
        text_addr_d   = text_addr_q;
        pat_addr_d    = pat_addr_q;
        match_valid_d = 1'b0;
        match_addr_d  = match_addr_q;
        cnt_clr       = 1'b0;
        cnt_en        = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    cnt_clr    = 1'b1;
                    base_d     = start_addr;
                    off_d      = '0;
                    text_end_d = text_end;
                    pat_len_d  = pat_len;
                    if (cfg_bad) begin
                        state_d = DONE;
                    end else begin
                        state_d     = FETCH;
                        text_addr_d = start_addr;
                        pat_addr_d  = '0;
                    end
                end
            end
            FETCH: begin
                state_d = abort ? IDLE : COMPARE;
            end
            COMPARE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (bytes_eq && !last_off) begin
                    off_d       = off_inc;
                    state_d     = FETCH;
                    text_addr_d = base_q + {{(TEXT_AW-PAT_AW){1'b0}}, off_inc};
                    pat_addr_d  = off_inc;
                end else begin
                    if (bytes_eq) begin
                        match_valid_d = 1'b1;
                        match_addr_d  = base_q;
                        cnt_en        = 1'b1;
                    end
                    base_d = base_q + TEXT_AW'(1);
                    off_d  = '0;
                    if (end_hit) begin
                        state_d = DONE;
                    end else begin
                        state_d     = FETCH;
                        text_addr_d = base_q + TEXT_AW'(1);
                        pat_addr_d  = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            base_q        <= '0;
            off_q         <= '0;
            text_end_q    <= '0;
            pat_len_q     <= '0;
            text_addr_q   <= '0;
            pat_addr_q    <= '0;
            match_valid_q <= 1'b0;
            match_addr_q  <= '0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            off_q         <= off_d;
            text_end_q    <= text_end_d;
            pat_len_q     <= pat_len_d;
            text_addr_q   <= text_addr_d;
            pat_addr_q    <= pat_addr_d;
            match_valid_q <= match_valid_d;
            match_addr_q  <= match_addr_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .cnt (match_count)
    );

    assign busy        = (state_q == FETCH) || (state_q == COMPARE);
    assign done        = state_q == DONE;
    assign text_addr   = text_addr_q;
    assign pat_addr    = pat_addr_q;
    assign match_valid = match_valid_q;
    assign match_addr  = match_addr_q;

endmodule

// File: tb/tb_match_scheduler.sv
// Directed bench for match_scheduler with behavioural synchronous text/pattern ROMs.
module tb_match_scheduler;

    localparam int TEXT_AW = 14;
    localparam int PAT_AW  = 3;
    localparam int DW      = 8;
    localparam int CNT_W   = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic [TEXT_AW-1:0] start_addr = '0;
    logic [TEXT_AW-1:0] text_end = '0;
    logic [PAT_AW:0]    pat_len = '0;
    logic [TEXT_AW-1:0] text_addr;
    logic [PAT_AW-1:0]  pat_addr;
    logic [DW-1:0]      text_data;
    logic [DW-1:0]      pat_data;
    logic               busy;
    logic               done;
    logic               match_valid;
    logic [TEXT_AW-1:0] match_addr;
    logic [CNT_W-1:0]   match_count;

    logic [DW-1:0] text_mem [0:(1<<TEXT_AW)-1];
    logic [DW-1:0] pat_mem  [0:(1<<PAT_AW)-1];

    int          errors = 0;
    int          checks = 0;
    int          pulses = 0;
    int unsigned addrs[$];
    int          p0 = 0;
    int          a0 = 0;

    match_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .start_addr  (start_addr),
        .text_end    (text_end),
        .pat_len     (pat_len),
        .text_addr   (text_addr),
        .pat_addr    (pat_addr),
        .text_data   (text_data),
        .pat_data    (pat_data),
        .busy        (busy),
        .done        (done),
        .match_valid (match_valid),
        .match_addr  (match_addr),
        .match_count (match_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        text_data <= text_mem[text_addr];
        pat_data  <= pat_mem[pat_addr];
    end

    always @(posedge clk) begin
        #1;
        if (match_valid === 1'b1) begin
            pulses++;
            addrs.push_back(32'(match_addr));
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] addr_at(input int idx);
        if (idx < addrs.size()) return addrs[idx];
        return 32'hFFFF_FFFF;
    endfunction

    task automatic load_text(input string s);
        for (int i = 0; i < 512; i++) text_mem[i] = '0;
        for (int i = 0; i < s.len(); i++) text_mem[i] = s[i];
    endtask

    task automatic load_pat(input string s);
        for (int i = 0; i < 8; i++) pat_mem[i] = '0;
        for (int i = 0; i < s.len(); i++) pat_mem[i] = s[i];
    endtask

    task automatic do_start(input int sa, input int te, input int len);
        @(negedge clk);
        start_addr = TEXT_AW'(sa);
        text_end   = TEXT_AW'(te);
        pat_len    = (PAT_AW+1)'(len);
        p0         = pulses;
        a0         = addrs.size();
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < (1<<TEXT_AW); i++) text_mem[i] = '0;
        load_pat("");

        // reset state
        #12;
        check("rst_busy",  32'(busy),        32'd0);
        check("rst_done",  32'(done),        32'd0);
        check("rst_mv",    32'(match_valid), 32'd0);
        check("rst_count", 32'(match_count), 32'd0);
        check("rst_maddr", 32'(match_addr),  32'd0);
        check("rst_taddr", 32'(text_addr),   32'd0);
        check("rst_paddr", 32'(pat_addr),    32'd0);
        @(negedge clk);
        rst = 1'b1;

        // abcabcab / abc: matches at 0 and 3, busy drops the cycle done rises
        load_text("abcabcab");
        load_pat("abc");
        do_start(0, 8, 3);
        begin
            logic prev_busy;
            int   n;
            prev_busy = busy;
            n = 0;
            while (done !== 1'b1 && n < 200) begin
                prev_busy = busy;
                @(negedge clk);
                n++;
            end
            check("s1_done",      32'(done),      32'd1);
            check("s1_busy_done", 32'(busy),      32'd0);
            check("s1_busy_prev", 32'(prev_busy), 32'd1);
        end
        check("s1_count",  32'(match_count), 32'd2);
        check("s1_pulses", 32'(pulses - p0), 32'd2);
        check("s1_addr0",  addr_at(a0),      32'd0);
        check("s1_addr1",  addr_at(a0 + 1),  32'd3);
        check("s1_maddr",  32'(match_addr),  32'd3);

        // abort is ignored once DONE
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        check("done_abort_done",  32'(done),        32'd1);
        check("done_abort_count", 32'(match_count), 32'd2);

        // aaaa / aa: overlapping matches at 0, 1, 2
        load_text("aaaa");
        load_pat("aa");
        do_start(0, 4, 2);
        wait_done("s2", 200);
        check("s2_count",  32'(match_count), 32'd3);
        check("s2_pulses", 32'(pulses - p0), 32'd3);
        check("s2_addr0",  addr_at(a0),      32'd0);
        check("s2_addr1",  addr_at(a0 + 1),  32'd1);
        check("s2_addr2",  addr_at(a0 + 2),  32'd2);

        // 300 x 'a' / a: counter saturates at 255, every alignment still pulses
        for (int i = 0; i < 300; i++) text_mem[i] = 8'h61;
        load_pat("a");
        do_start(0, 300, 1);
        wait_done("s3", 1500);
        check("s3_count",  32'(match_count), 32'd255);
        check("s3_pulses", 32'(pulses - p0), 32'd300);
        check("s3_maddr",  32'(match_addr),  32'd299);

        // pat_len=0: straight to DONE, count cleared, ROM address untouched
        do_start(0, 300, 0);
        check("len0_done",  32'(done),        32'd1);
        check("len0_busy",  32'(busy),        32'd0);
        check("len0_count", 32'(match_count), 32'd0);
        check("len0_taddr", 32'(text_addr),   32'd299);

        // pat_len=9 after a scan with a nonzero count
        load_text("aaaa");
        load_pat("aa");
        do_start(0, 4, 2);
        wait_done("s2b", 200);
        check("s2b_count", 32'(match_count), 32'd3);
        do_start(0, 100, 9);
        check("len9_done",  32'(done),        32'd1);
        check("len9_count", 32'(match_count), 32'd0);
        check("len9_taddr", 32'(text_addr),   32'd3);

        // start_addr+pat_len exceeds text_end
        do_start(6, 8, 3);
        check("win_done", 32'(done), 32'd1);
        check("win_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check("win_hold_done", 32'(done),        32'd1);
        check("win_count",     32'(match_count), 32'd0);
        check("win_taddr",     32'(text_addr),   32'd3);
        check("win_paddr",     32'(pat_addr),    32'd1);
        check("win_pulses",    32'(pulses - p0), 32'd0);

        // abort on the COMPARE cycle of the second match
        load_text("abcabcab");
        load_pat("abc");
        do_start(0, 8, 3);
        begin
            int n = 0;
            while (!(busy === 1'b1 && text_addr == 14'd5 && pat_addr == 3'd2) && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("ab_reach", 32'(n < 200), 32'd1);
        end
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("ab_busy",  32'(busy),        32'd0);
        check("ab_done",  32'(done),        32'd0);
        check("ab_count", 32'(match_count), 32'd1);
        repeat (3) @(negedge clk);
        check("ab_pulses", 32'(pulses - p0), 32'd1);
        check("ab_idle",   32'(busy | done), 32'd0);
        do_start(0, 8, 3);
        check("ab_restart_count", 32'(match_count), 32'd0);
        check("ab_restart_busy",  32'(busy),        32'd1);
        wait_done("ab_rerun", 200);
        check("ab_rerun_count", 32'(match_count), 32'd2);

        // asynchronous reset mid-scan
        do_start(0, 8, 3);
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("mr_busy",  32'(busy),        32'd0);
        check("mr_done",  32'(done),        32'd0);
        check("mr_mv",    32'(match_valid), 32'd0);
        check("mr_count", 32'(match_count), 32'd0);
        check("mr_maddr", 32'(match_addr),  32'd0);
        check("mr_taddr", 32'(text_addr),   32'd0);
        check("mr_paddr", 32'(pat_addr),    32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mr_post_idle", 32'(busy | done), 32'd0);
        do_start(0, 8, 3);
        wait_done("mr_scan", 200);
        check("mr_scan_count",  32'(match_count), 32'd2);
        check("mr_scan_pulses", 32'(pulses - p0), 32'd2);
        check("mr_scan_addr0",  addr_at(a0),      32'd0);
        check("mr_scan_addr1",  addr_at(a0 + 1),  32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
